dds_waveform_generator: RTL and testbench



---
 rtl/dds_waveform_generator.sv | 181 ++++++++++++++++++
 tb/tb_dds_waveform_generator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_waveform_generator.sv
// DDS waveform generator: phase accumulator feeding a two-stage shaping pipeline
// (sawtooth, square, triangle, sine family, noise, midscale) with amplitude attenuation.
module dds_waveform_generator #(
  parameter int                 DATA_W  = 8,
  parameter int                 PHASE_W = 16,
  parameter logic [PHASE_W-1:0] FTW_RST = PHASE_W'(1) << (PHASE_W - DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_load,
  input  logic [2:0]         slc,
  input  logic [DATA_W-1:0]  duty,
  input  logic [1:0]         amp,
  output logic [DATA_W-1:0]  out,
  output logic               out_valid,
  output logic               wrap
);

  localparam int                LUT_N  = 1 << (DATA_W - 2);
  localparam int                MID_I  = 1 << (DATA_W - 1);
  localparam logic [DATA_W-1:0] MID    = DATA_W'(MID_I);
  localparam logic [DATA_W-1:0] MID_M1 = DATA_W'(MID_I - 1);
  localparam logic [DATA_W-1:0] FS     = '1;

  // Galois feedback masks giving a maximal-length sequence for each width.
  function automatic logic [DATA_W-1:0] lfsr_taps(input int w);
    case (w)
      3:       return DATA_W'(16'h0006);
      4:       return DATA_W'(16'h000C);
      5:       return DATA_W'(16'h0014);
      6:       return DATA_W'(16'h0030);
      7:       return DATA_W'(16'h0060);
      8:       return DATA_W'(16'h00B8);
      9:       return DATA_W'(16'h0110);
      10:      return DATA_W'(16'h0240);
      11:      return DATA_W'(16'h0500);
      12:      return DATA_W'(16'h0E08);
      13:      return DATA_W'(16'h1C80);
      14:      return DATA_W'(16'h3802);
      15:      return DATA_W'(16'h6000);
      default: return DATA_W'(16'hD008);
    endcase
  endfunction

  localparam logic [DATA_W-1:0] LFSR_TAPS = lfsr_taps(DATA_W);

  // Quarter-wave entry round((M-1)*sin(pi/2*(i+0.5)/LUT_N)), evaluated in Q30 fixed point
  // with a Taylor series so the table folds to constants at elaboration.
  function automatic int sin_entry(input int i);
    longint x, x2, term, sum;
    x    = (longint'(1686629713) * longint'(2 * i + 1)) / longint'(2 * LUT_N);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return int'((longint'(MID_I - 1) * sum + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [DATA_W-2:0] sin_lut [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam int                QV_I = sin_entry(gi);
    localparam logic [DATA_W-2:0] QV   = QV_I[DATA_W-2:0];
    assign sin_lut[gi] = QV;
  end

  // Stage 0 state
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W:0]   acc_sum;
  logic [DATA_W-1:0]  lfsr;
  logic [DATA_W-1:0]  lfsr_next;

  // Stage 1 state
  logic [DATA_W-1:0]  p1;
  logic [2:0]         slc1;
  logic [DATA_W-1:0]  duty1;
  logic [1:0]         amp1;
  logic [DATA_W-1:0]  noise1;
  logic               valid1;

  // Shaping datapath
  logic [1:0]           quad;
  logic [DATA_W-3:0]    lut_a;
  logic [DATA_W-1:0]    sine;
  logic [DATA_W-1:0]    tri_w;
  logic [DATA_W-1:0]    wave;
  logic signed [DATA_W:0] dev;
  logic signed [DATA_W:0] dev_sh;
  logic [DATA_W-1:0]    shaped;

  assign acc_sum   = {1'b0, acc} + {1'b0, ftw};
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);

  // Stage 0: FTW capture (independent of en), phase accumulation, wrap pulse, noise source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ftw  <= FTW_RST;
      acc  <= '0;
      wrap <= 1'b0;
      lfsr <= '1;
    end else begin
      if (ftw_load) ftw <= ftw_in;
      if (en) begin
        acc  <= acc_sum[PHASE_W-1:0];
        wrap <= acc_sum[PHASE_W];
        lfsr <= lfsr_next;
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  // Stage 1: latch phase and all shaping controls together so a sample is self-consistent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1     <= '0;
      slc1   <= '0;
      duty1  <= '0;
      amp1   <= '0;
      noise1 <= '0;
    end else if (en) begin
      p1     <= acc[PHASE_W-1 -: DATA_W];
      slc1   <= slc;
      duty1  <= duty;
      amp1   <= amp;
      noise1 <= lfsr;
    end
  end

  // Waveform selection and attenuation about midscale.
  always_comb begin
    quad  = p1[DATA_W-1 -: 2];
    lut_a = p1[DATA_W-3:0];
    sine  = MID;
    case (quad)
      2'd0: sine = MID + {1'b0, sin_lut[lut_a]};
      2'd1: sine = MID + {1'b0, sin_lut[~lut_a]};
      2'd2: sine = MID_M1 - {1'b0, sin_lut[lut_a]};
      2'd3: sine = MID_M1 - {1'b0, sin_lut[~lut_a]};
    endcase

    tri_w = {p1[DATA_W-2:0], 1'b0};
    if (p1[DATA_W-1]) tri_w = ~tri_w;

    wave = MID;
    case (slc1)
      3'b000:  wave = p1;
      3'b001:  wave = (p1 < duty1) ? FS : '0;
      3'b010:  wave = tri_w;
      3'b011:  wave = sine;
      3'b100:  wave = (sine >= MID) ? sine : (FS - sine);
      3'b101:  wave = (sine >= MID) ? sine : MID;
      3'b110:  wave = noise1;
      default: wave = MID;
    endcase

    dev    = $signed({1'b0, wave}) - $signed({1'b0, MID});
    dev_sh = dev >>> amp1;
    shaped = DATA_W'(dev_sh + $signed({1'b0, MID}));
  end

  // Stage 2: registered output; the valid flag tracks en through both stages every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      valid1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      valid1    <= en;
      out_valid <= valid1;
      if (en) out <= shaped;
    end
  end

endmodule

// File: tb/tb_dds_waveform_generator.sv
// Self-checking bench for dds_waveform_generator: directed spot values plus
// randomized runs compared against a behavioural sample model.
module tb_dds_waveform_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] ftw_in = '0;
  logic        ftw_load = 1'b0;
  logic [2:0]  slc = '0;
  logic [7:0]  duty = '0;
  logic [1:0]  amp = '0;
  logic [7:0]  out;
  logic        out_valid;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase, tuning word, expected outputs, and the sample waiting one enabled edge.
  int m_acc, m_ftw, m_wrap, m_v1, m_valid, m_out, m_out_noise;
  int pend, pend_noise;
  int q_lut [64];

  always #5 clk = ~clk;

  dds_waveform_generator #(.DATA_W(8), .PHASE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ftw_in    (ftw_in),
    .ftw_load  (ftw_load),
    .slc       (slc),
    .duty      (duty),
    .amp       (amp),
    .out       (out),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sine_of(input int p);
    int a;
    a = p % 64;
    case (p / 64)
      0:       return 128 + q_lut[a];
      1:       return 128 + q_lut[63 - a];
      2:       return 127 - q_lut[a];
      default: return 127 - q_lut[63 - a];
    endcase
  endfunction

  function automatic int shape(input int p, input int s, input int d, input int a);
    int w, sn, t;
    sn = sine_of(p);
    case (s)
      0: w = p;
      1: w = (p < d) ? 255 : 0;
      2: begin
        t = (2 * p) % 256;
        w = (p >= 128) ? 255 - t : t;
      end
      3: w = sn;
      4: w = (sn >= 128) ? sn : 255 - sn;
      5: w = (sn >= 128) ? sn : 128;
      default: w = 128;
    endcase
    return 128 + ((w - 128) >>> a);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ftw = 256; m_wrap = 0; m_v1 = 0; m_valid = 0;
    m_out = 0; m_out_noise = 0; pend = 0; pend_noise = 0;
  endtask

  // One clock: update the model from the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk);
    m_valid = m_v1;
    m_v1    = int'(en);
    if (en) begin
      m_out       = pend;
      m_out_noise = pend_noise;
      pend_noise  = int'(slc == 3'd6);
      pend        = shape(m_acc / 256, int'(slc), int'(duty), int'(amp));
      m_wrap      = int'(m_acc + m_ftw >= 65536);
      m_acc       = (m_acc + m_ftw) % 65536;
    end else begin
      m_wrap = 0;
    end
    if (ftw_load) m_ftw = int'(ftw_in);
    #1;
    if (m_out_noise == 0) check("out", int'(out), m_out);
    check("out_valid", int'(out_valid), m_valid);
    check("wrap", int'(wrap), m_wrap);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_wrap", int'(wrap), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Run from reset with the default FTW until the sample for phase p is on out.
  task automatic spot(input string tag, input int s, input int a, input int d, input int p, input int exp);
    apply_reset();
    slc = 3'(s); amp = 2'(a); duty = 8'(d); en = 1'b1; ftw_load = 1'b0;
    repeat (p + 2) step();
    check(tag, int'(out), exp);
  endtask

  initial begin
    int wraps, held, distinct;
    int samp [257];
    bit seen [256];

    for (int i = 0; i < 64; i++)
      q_lut[i] = $rtoi(127.0 * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / 64.0) + 0.5);
    model_reset();
    #3;

    // Sawtooth from reset: wrap every 256 enabled cycles.
    apply_reset();
    slc = 3'd0; amp = 2'd0; en = 1'b1;
    wraps = 0;
    for (int i = 0; i < 520; i++) begin
      step();
      if (wrap) wraps++;
      if (i == 1) check("first_valid", int'(out_valid), 1);
    end
    check("wrap_count", wraps, 2);

    // Directed shape values at known phases.
    spot("tri_00", 2, 0, 0, 8'h00, 8'h00);
    spot("tri_7f", 2, 0, 0, 8'h7F, 8'hFE);
    spot("tri_80", 2, 0, 0, 8'h80, 8'hFF);
    spot("tri_ff", 2, 0, 0, 8'hFF, 8'h01);
    spot("sq_3f", 1, 0, 8'h40, 8'h3F, 8'hFF);
    spot("sq_40", 1, 0, 8'h40, 8'h40, 8'h00);
    spot("sq_duty0", 1, 0, 8'h00, 8'h00, 8'h00);
    spot("sq_dutyfs", 1, 0, 8'hFF, 8'hFF, 8'h00);
    spot("sin_00", 3, 0, 0, 8'h00, 130);
    spot("sin_40", 3, 0, 0, 8'h40, 255);
    spot("sin_c0", 3, 0, 0, 8'hC0, 0);
    spot("full_c0", 4, 0, 0, 8'hC0, 255);
    spot("half_c0", 5, 0, 0, 8'hC0, 128);
    spot("amp_00", 0, 1, 0, 8'h00, 8'h40);
    spot("amp_ff", 0, 1, 0, 8'hFF, 8'hBF);
    spot("mid_amp3", 7, 3, 0, 8'h37, 8'h80);

    // FTW reload at acc=0x1000: increments 0x0100 then 0x0400.
    apply_reset();
    slc = 3'd0; amp = 2'd0; en = 1'b1;
    repeat (16) step();
    ftw_in = 16'h0400; ftw_load = 1'b1;
    step();
    ftw_load = 1'b0;
    step();
    step();
    check("ftw_p1", int'(out), 8'h11);
    step();
    check("ftw_p2", int'(out), 8'h15);

    // Enable gating: out frozen, out_valid falls two cycles after en.
    held = int'(out);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frozen", int'(out), held);
      check("valid_gate", int'(out_valid), (i >= 1) ? 0 : 1);
    end
    en = 1'b1;
    repeat (4) step();

    // Noise: maximal-length sequence of nonzero values.
    apply_reset();
    slc = 3'd6; amp = 2'd0; en = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 257; i++) begin
      samp[i] = int'(out);
      step();
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (samp[i] != 0 && !seen[samp[i]]) begin
        distinct++;
        seen[samp[i]] = 1'b1;
      end
    end
    check("noise_distinct", distinct, 255);
    check("noise_period", samp[255], samp[0]);

    // Randomized operation, including a mid-run reset while enabled.
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) begin
        slc  = 3'($urandom_range(0, 7));
        duty = 8'($urandom);
        amp  = 2'($urandom);
      end
      en       = ($urandom_range(0, 4) != 0);
      ftw_load = ($urandom_range(0, 39) == 0);
      ftw_in   = 16'($urandom);
      if (i == 2000) begin
        en = 1'b1;
        ftw_load = 1'b0;
        step();
        apply_reset();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
